alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU (ADD/SUB/AND/OR/XOR, 4-bit op) between two requesters, e.g. execute unit (port 0) and address/branch unit (port 1).
- Round-robin grant, valid/ready request handshake, result registered and held until the requester accepts it.
- Sits between the requesting units and the ALU instance; the ALU itself stays a separate, unmodified instance.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/rr_arbiter2.sv | 11 +
 rtl/alu_arbiter.sv | 80 ++++++++
 tb/tb_alu_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, widths and arbiter state encoding
package alu_pkg;
   localparam int DATA_W = 32;
   localparam int OP_W = 4;
   localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
   localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
   localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
   typedef enum logic {IDLE, RESP} arb_state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshakes plus the shared ALU connection
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DW = DATA_W,
   parameter int OW = OP_W
);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   logic [NUM_REQ*DW-1:0] req_a;
   logic [NUM_REQ*DW-1:0] req_b;
   logic [NUM_REQ*OW-1:0] req_op;
   logic [NUM_REQ-1:0] resp_valid;
   logic [NUM_REQ-1:0] resp_ready;
   logic [DW-1:0] resp_result;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_result;
   modport slave (
      input req_valid, req_a, req_b, req_op, resp_ready, alu_result,
      output req_ready, resp_valid, resp_result, alu_a, alu_b, alu_op
   );
   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready, alu_result,
      input req_ready, resp_valid, resp_result, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick, ptr names the preferred requester
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);
   always_comb begin
      grant[0] = valid[0] & (~ptr | ~valid[1]);
      grant[1] = valid[1] & (ptr | ~valid[0]);
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, registered held result
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DW = DATA_W,
   parameter int OW = OP_W
) (
   input logic clk,
   input logic rst,
   alu_arbiter_if.slave bus
);
   if (NUM_REQ != 2) begin : g_bad_num_req
      $error("alu_arbiter supports NUM_REQ == 2 only");
   end
   arb_state_e state_q, state_d;
   logic rr_ptr_q, rr_ptr_d;
   logic resp_owner_q, resp_owner_d;
   logic [DW-1:0] resp_result_q, resp_result_d;
   logic [1:0] grant;
   logic gidx;
   logic [1:0] req_ready;
   logic [1:0] resp_valid;
   logic [DW-1:0] alu_a, alu_b;
   logic [OW-1:0] alu_op;
   rr_arbiter2 u_rr (
      .valid (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );
   assign gidx = grant[1];
   always_comb begin
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      resp_owner_d = resp_owner_q;
      resp_result_d = resp_result_q;
      req_ready = '0;
      resp_valid = '0;
      alu_a = '0;
      alu_b = '0;
      alu_op = '0;
      if (state_q == IDLE) begin
         req_ready = grant;
         // a nonzero grant already implies valid & ready, so this is the accepting edge
         if (|grant) begin
            alu_a = gidx ? bus.req_a[DW +: DW] : bus.req_a[0 +: DW];
            alu_b = gidx ? bus.req_b[DW +: DW] : bus.req_b[0 +: DW];
            alu_op = gidx ? bus.req_op[OW +: OW] : bus.req_op[0 +: OW];
            resp_result_d = bus.alu_result;
            resp_owner_d = gidx;
            state_d = RESP;
         end
      end else begin
         resp_valid = resp_owner_q ? 2'b10 : 2'b01;
         if (bus.resp_ready[resp_owner_q]) begin
            state_d = IDLE;
            rr_ptr_d = ~resp_owner_q;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_ptr_q <= 1'b0;
         resp_owner_q <= 1'b0;
         resp_result_q <= '0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         resp_owner_q <= resp_owner_d;
         resp_result_q <= resp_result_d;
      end
   end
   assign bus.req_ready = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_result = resp_result_q;
   assign bus.alu_a = alu_a;
   assign bus.alu_b = alu_b;
   assign bus.alu_op = alu_op;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors against the arbiter with a behavioural ALU attached
module tb_alu_arbiter;
   import alu_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int chk_cnt = 0;
   int pass_cnt = 0;
   alu_arbiter_if bus ();
   alu_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   always_comb begin
      case (bus.alu_op)
         ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
         ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
         ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
         ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
         ALU_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
         default: bus.alu_result = '0;
      endcase
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      bus.req_valid[i] = v;
      bus.req_a[i*32 +: 32] = a;
      bus.req_b[i*32 +: 32] = b;
      bus.req_op[i*4 +: 4] = op;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask
   initial begin
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_op = '0;
      bus.resp_ready = '0;
      do_reset();
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("rst_resp_result", bus.resp_result, 32'h0);
      check("rst_alu_a", bus.alu_a, 32'h0);
      check("rst_alu_op", 32'(bus.alu_op), 32'h0);
      // single op
      set_req(0, 1, 32'd5, 32'd7, ALU_ADD);
      bus.resp_ready = 2'b11;
      #1;
      check("single_req_ready", 32'(bus.req_ready), 32'h1);
      check("single_alu_a", bus.alu_a, 32'd5);
      check("single_alu_b", bus.alu_b, 32'd7);
      tick();
      bus.req_valid[0] = 1'b0;
      #1;
      check("single_resp_valid", 32'(bus.resp_valid), 32'h1);
      check("single_result", bus.resp_result, 32'd12);
      check("single_resp_req_ready", 32'(bus.req_ready), 32'h0);
      check("single_resp_alu_a", bus.alu_a, 32'h0);
      tick();
      check("single_back_idle", 32'(bus.resp_valid), 32'h0);
      // contention from reset: req0 first, then req1, then alternation
      do_reset();
      set_req(0, 1, 32'd10, 32'd3, ALU_SUB);
      set_req(1, 1, 32'h0000F0F0, 32'h00000FF0, ALU_XOR);
      #1;
      check("cont_grant0", 32'(bus.req_ready), 32'h1);
      tick();
      check("cont_resp0_valid", 32'(bus.resp_valid), 32'h1);
      check("cont_resp0_result", bus.resp_result, 32'd7);
      tick();
      check("cont_grant1", 32'(bus.req_ready), 32'h2);
      tick();
      check("cont_resp1_valid", 32'(bus.resp_valid), 32'h2);
      check("cont_resp1_result", bus.resp_result, 32'h0000FF00);
      // fairness: both stay valid, grants must alternate starting with 0
      set_req(0, 1, 32'd1, 32'd2, ALU_ADD);
      set_req(1, 1, 32'h100, 32'h1, ALU_OR);
      tick();
      for (int k = 0; k < 10; k++) begin
         check($sformatf("fair_grant_%0d", k), 32'(bus.req_ready), (k % 2) ? 32'h2 : 32'h1);
         tick();
         check($sformatf("fair_owner_%0d", k), 32'(bus.resp_valid), (k % 2) ? 32'h2 : 32'h1);
         check($sformatf("fair_result_%0d", k), bus.resp_result, (k % 2) ? 32'h101 : 32'h3);
         tick();
      end
      // backpressure on req1 with req0 stalled behind it
      bus.req_valid = '0;
      bus.resp_ready = 2'b00;
      set_req(1, 1, 32'hFFFF0000, 32'h12345678, ALU_AND);
      #1;
      check("bp_grant1", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid[1] = 1'b0;
      set_req(0, 1, 32'hFFFFFFFF, 32'd1, ALU_ADD);
      for (int k = 0; k < 5; k++) begin
         bus.resp_ready = (k == 2) ? 2'b01 : 2'b00;
         #1;
         check($sformatf("bp_result_%0d", k), bus.resp_result, 32'h12340000);
         check($sformatf("bp_valid_%0d", k), 32'(bus.resp_valid), 32'h2);
         check($sformatf("bp_ready_%0d", k), 32'(bus.req_ready), 32'h0);
         tick();
      end
      bus.resp_ready = 2'b10;
      tick();
      bus.resp_ready = 2'b11;
      #1;
      check("bp_release_grant0", 32'(bus.req_ready), 32'h1);
      check("wrap_alu_a", bus.alu_a, 32'hFFFFFFFF);
      tick();
      check("wrap_result", bus.resp_result, 32'h0);
      check("wrap_valid", 32'(bus.resp_valid), 32'h1);
      set_req(0, 1, 32'hFFFFFFFF, 32'd3, ALU_ADD);
      tick();
      tick();
      check("wrap3_result", bus.resp_result, 32'd2);
      set_req(0, 1, 32'd5, 32'd3, 4'hF);
      tick();
      check("undef_alu_op", 32'(bus.alu_op), 32'hF);
      check("undef_grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid[0] = 1'b0;
      #1;
      check("undef_result", bus.resp_result, 32'h0);
      check("undef_valid", 32'(bus.resp_valid), 32'h1);
      tick();
      check("undef_done", 32'(bus.resp_valid), 32'h0);
      // reset while a response is pending
      bus.resp_ready = 2'b00;
      set_req(0, 1, 32'd9, 32'd9, ALU_ADD);
      tick();
      bus.req_valid[0] = 1'b0;
      #1;
      check("mid_resp_valid", 32'(bus.resp_valid), 32'h1);
      check("mid_resp_result", bus.resp_result, 32'd18);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.resp_valid), 32'h0);
      check("mid_rst_result", bus.resp_result, 32'h0);
      bus.resp_ready = 2'b11;
      set_req(0, 1, 32'd1, 32'd1, ALU_ADD);
      set_req(1, 1, 32'd20, 32'd5, ALU_SUB);
      #1;
      check("mid_rst_ptr0", 32'(bus.req_ready), 32'h1);
      bus.req_valid[0] = 1'b0;
      #1;
      check("mid_req1_grant", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid[1] = 1'b0;
      #1;
      check("mid_req1_valid", 32'(bus.resp_valid), 32'h2);
      check("mid_req1_result", bus.resp_result, 32'd15);
      tick();
      check("mid_req1_done", 32'(bus.resp_valid), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
